// File: rtl/matrix_row_scanner_pkg.sv
// Shared definitions for the 7x5 dot-matrix row scanner: geometry, FSM encoding and glyph presets.
package matrix_row_scanner_pkg;

    localparam int NUM_ROWS = 7;
    localparam int NUM_COLS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } state_t;

    // Glyph presets indexed [symbol][row]; bit 4 is the leftmost column.
    localparam logic [NUM_COLS-1:0] FONT [4][NUM_ROWS] = '{
        '{5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b01111, 5'b01110},
        '{5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110},
        '{5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10100, 5'b11010, 5'b10001},
        '{5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b11111}
    };

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [NUM_COLS-1:0] row_preset(input logic [1:0] sym, input int r);
        return FONT[sym][r];
    endfunction

endpackage

// File: rtl/matrix_row_scanner_preset_rom.sv
// Combinational glyph lookup: one preset block per row, selected by row index.
module matrix_preset_rom
    import matrix_row_scanner_pkg::*;
(
    input  logic [1:0]          sym,
    input  logic [2:0]          row_idx,
    output logic [NUM_COLS-1:0] cols
);

    logic [NUM_COLS-1:0] row_cols [NUM_ROWS];

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        assign row_cols[r] = row_preset(sym, r);
    end

    // Index 7 has no row behind it and reads as dark.
    always_comb begin
        cols = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_idx == 3'(r)) cols = row_cols[r];
        end
    end

endmodule

// File: rtl/matrix_row_scanner.sv
// Row-sequencing FSM for the 7x5 matrix: drives one row at a time with optional blanking gaps.
module matrix_row_scanner
    import matrix_row_scanner_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          HH,
    output logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] cl,
    output logic                frame_done,
    output logic                busy,
    output state_t              dbg_state
);

    localparam int CNT_W = $clog2(max3(CLK_DIV, BLANK_CYC, 2));
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    state_t           state;
    logic [2:0]       row_idx;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sym_q;

    logic             wrap;
    logic             advance;
    logic [2:0]       load_idx;
    logic [1:0]       load_sym;
    logic [NUM_COLS-1:0] load_cols;

    // load_idx/load_sym describe the row about to be driven, either at scan start or on advance.
    always_comb begin
        wrap     = (row_idx == 3'(NUM_ROWS - 1));
        advance  = 1'b0;
        if (state == DRIVE && cnt == DRIVE_LAST && BLANK_CYC == 0) advance = 1'b1;
        if (state == BLANK && cnt == BLANK_LAST) advance = 1'b1;
        load_idx = 3'd0;
        load_sym = HH;
        if (state != IDLE) begin
            load_idx = wrap ? 3'd0 : row_idx + 3'd1;
            load_sym = wrap ? HH : sym_q;
        end
    end

    matrix_preset_rom u_rom (
        .sym     (load_sym),
        .row_idx (load_idx),
        .cols    (load_cols)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row_idx    <= '0;
            cnt        <= '0;
            sym_q      <= 2'b00;
            row        <= '0;
            cl         <= '0;
            frame_done <= 1'b0;
        end else if (!en) begin
            state      <= IDLE;
            row_idx    <= '0;
            cnt        <= '0;
            row        <= '0;
            cl         <= '0;
            frame_done <= 1'b0;
        end else if (advance) begin
            state      <= DRIVE;
            row_idx    <= load_idx;
            sym_q      <= load_sym;
            cnt        <= '0;
            row        <= NUM_ROWS'(1) << load_idx;
            cl         <= load_cols;
            frame_done <= wrap;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    state   <= DRIVE;
                    row_idx <= '0;
                    cnt     <= '0;
                    sym_q   <= load_sym;
                    row     <= NUM_ROWS'(1);
                    cl      <= load_cols;
                end
                DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        state <= BLANK;
                        cnt   <= '0;
                        row   <= '0;
                        cl    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BLANK: cnt <= cnt + CNT_W'(1);
                default: begin
                    state   <= IDLE;
                    row_idx <= '0;
                    cnt     <= '0;
                    row     <= '0;
                    cl      <= '0;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Directed bench for matrix_row_scanner: a blanking instance (4,1) and a gapless instance (4,0).
module tb_matrix_row_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       en0 = 1'b0;
    logic [1:0] HH  = 2'b00;

    logic [6:0] row, row0;
    logic [4:0] cl, cl0;
    logic       frame_done, frame_done0, busy, busy0;
    logic [1:0] st, st0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [4:0] pat [4][7] = '{
        '{5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b01111, 5'b01110},
        '{5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110},
        '{5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10100, 5'b11010, 5'b10001},
        '{5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b11111}
    };

    always #5 clk = ~clk;

    matrix_row_scanner #(.CLK_DIV(4), .BLANK_CYC(1)) dut (
        .clk(clk), .rst(rst), .en(en), .HH(HH), .row(row), .cl(cl),
        .frame_done(frame_done), .busy(busy), .dbg_state(st)
    );

    matrix_row_scanner #(.CLK_DIV(4), .BLANK_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .HH(HH), .row(row0), .cl(cl0),
        .frame_done(frame_done0), .busy(busy0), .dbg_state(st0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected values for the blanking instance at scan cycle c (1 = first driven cycle).
    function automatic logic [6:0] exp_row(input int c);
        int f = (c - 1) % 35;
        return (f % 5 < 4) ? (7'd1 << (f / 5)) : 7'd0;
    endfunction

    function automatic logic [4:0] exp_cl(input int c, input logic [1:0] s);
        int f = (c - 1) % 35;
        return (f % 5 < 4) ? pat[s][f / 5] : 5'd0;
    endfunction

    function automatic logic exp_fd(input int c);
        return (c > 35) && ((c - 1) % 35 == 0);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (row !== 7'd0 || cl !== 5'd0 || busy !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset: row=%b cl=%b busy=%b fd=%b, want all zero", row, cl, busy, frame_done);
            end
            checks++;
            if (row0 !== 7'd0 || cl0 !== 5'd0 || busy0 !== 1'b0 || frame_done0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_nb: row=%b cl=%b busy=%b fd=%b, want all zero", row0, cl0, busy0, frame_done0);
            end
        end
        en  = 1'b0;
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || row !== 7'd0) begin
            errors++;
            $display("FAIL idle: busy=%b row=%b, want 0 0", busy, row);
        end
    endtask

    task automatic test_scan();
        HH = 2'b00;
        en = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            step();
            cyc = c;
            checks++;
            if (row !== exp_row(c) || cl !== exp_cl(c, 2'b00) || frame_done !== exp_fd(c)) begin
                errors++;
                $display("FAIL scan c=%0d: row=%b cl=%b fd=%b, want %b %b %b",
                         c, row, cl, frame_done, exp_row(c), exp_cl(c, 2'b00), exp_fd(c));
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_scan: got %b want 1", busy);
        end
    endtask

    // HH flips during row 3 of the second frame; only the third frame may show it.
    task automatic test_symbol_change();
        logic [1:0] s;
        for (int c = 37; c <= 105; c++) begin
            step();
            cyc = c;
            if (c == 47) HH = 2'b10;
            s = (c <= 70) ? 2'b00 : 2'b10;
            checks++;
            if (row !== exp_row(c) || cl !== exp_cl(c, s) || frame_done !== exp_fd(c)) begin
                errors++;
                $display("FAIL symchg c=%0d: row=%b cl=%b fd=%b, want %b %b %b",
                         c, row, cl, frame_done, exp_row(c), exp_cl(c, s), exp_fd(c));
            end
        end
    endtask

    task automatic test_en_drop();
        for (int c = 106; c <= 122; c++) begin
            step();
            cyc = c;
            checks++;
            if (row !== exp_row(c) || cl !== exp_cl(c, 2'b10) || frame_done !== exp_fd(c)) begin
                errors++;
                $display("FAIL pre_drop c=%0d: row=%b cl=%b fd=%b, want %b %b %b",
                         c, row, cl, frame_done, exp_row(c), exp_cl(c, 2'b10), exp_fd(c));
            end
        end
        en = 1'b0;
        step();
        checks++;
        if (row !== 7'd0 || cl !== 5'd0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL en_drop: row=%b cl=%b busy=%b fd=%b, want all zero", row, cl, busy, frame_done);
        end
        HH = 2'b11;
        en = 1'b1;
        step();
        cyc = 1;
        checks++;
        if (row !== 7'b0000001 || cl !== 5'b11111 || busy !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL restart: row=%b cl=%b busy=%b fd=%b, want 0000001 11111 1 0", row, cl, busy, frame_done);
        end
    endtask

    task automatic test_reset_mid_blank();
        for (int c = 2; c <= 5; c++) begin
            step();
            cyc = c;
            checks++;
            if (row !== exp_row(c) || cl !== exp_cl(c, 2'b11)) begin
                errors++;
                $display("FAIL pre_rst c=%0d: row=%b cl=%b, want %b %b", c, row, cl, exp_row(c), exp_cl(c, 2'b11));
            end
        end
        rst = 1'b1;
        step();
        checks++;
        if (row !== 7'd0 || cl !== 5'd0 || busy !== 1'b0 || frame_done !== 1'b0 || st !== 2'd0) begin
            errors++;
            $display("FAIL mid_rst: row=%b cl=%b busy=%b fd=%b st=%0d, want all zero", row, cl, busy, frame_done, st);
        end
        step();
        rst = 1'b0;
        HH  = 2'b01;
        step();
        checks++;
        if (row !== 7'b0000001 || cl !== 5'b00100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL post_rst: row=%b cl=%b busy=%b, want 0000001 00100 1", row, cl, busy);
        end
        en = 1'b0;
        step();
    endtask

    task automatic test_no_blank();
        int f;
        logic [6:0] er;
        logic       efd;
        HH  = 2'b01;
        en0 = 1'b1;
        for (int c = 1; c <= 57; c++) begin
            step();
            f   = (c - 1) % 28;
            er  = 7'd1 << (f / 4);
            efd = (c > 28) && (f == 0);
            checks++;
            if (row0 !== er || cl0 !== pat[1][f / 4] || frame_done0 !== efd || $countones(row0) > 1) begin
                errors++;
                $display("FAIL noblank c=%0d: row=%b cl=%b fd=%b, want %b %b %b",
                         c, row0, cl0, frame_done0, er, pat[1][f / 4], efd);
            end
        end
        checks++;
        if (row !== 7'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL other_idle: row=%b busy=%b, want 0 0", row, busy);
        end
        en0 = 1'b0;
        step();
        checks++;
        if (row0 !== 7'd0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL noblank_stop: row=%b busy=%b, want 0 0", row0, busy0);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_symbol_change();
        test_en_drop();
        test_reset_mid_blank();
        test_no_blank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
